// File: rtl/spi_regfile_rx_pkg.sv
// Shared definitions for the SPI register-file write receiver.
// Holds the default register/CPU widths, the frame length helper
// and the receiver FSM state encoding used by spi_regfile_rx.
`ifndef W_REG
`define W_REG 5
`endif
`ifndef W_CPU
`define W_CPU 32
`endif

package spi_regfile_rx_pkg;

  localparam int W_REG_DEF = `W_REG;
  localparam int W_CPU_DEF = `W_CPU;

  // A frame is one register address followed by one data word, MSB first.
  function automatic int frameLen(input int wAddr, input int wData);
    return wAddr + wData;
  endfunction

  localparam int F_LEN = frameLen(W_REG_DEF, W_CPU_DEF);

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_SHIFT  = 2'd1,
    RX_COMMIT = 2'd2,
    RX_DRAIN  = 2'd3
  } rxState_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin.
// Ports:
//   clk    - core clock
//   rst_n  - asynchronous active-low reset, loads RST_VAL into every stage
//   d_i    - asynchronous pin
//   q_o    - pin value synchronized to clk (STAGES cycles of delay)
module spi_pin_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Reset value matches the pin's idle level so no false edge appears
  // when reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_regfile_rx.sv
// SPI mode-0 slave receiver that turns address+data frames into single
// write requests on the shared register-file write port.
// Ports:
//   clk, rst       - core clock, asynchronous active-low reset
//   sclk/cs_n/mosi - asynchronous SPI pins, oversampled in the clk domain
//   wr_req/wr_gnt  - write handshake toward the register-file arbiter
//   wa/wd          - write address/data, held stable while wr_req=1
//   frame_err      - one-cycle pulse on aborted or over-long frames
//   ovf/clr_ovf    - sticky dropped-frame flag and its synchronous clear
module spi_regfile_rx
  import spi_regfile_rx_pkg::*;
#(
  parameter int W_ADDR      = W_REG_DEF,
  parameter int W_DATA      = W_CPU_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              wr_req,
  input  logic              wr_gnt,
  output logic [W_ADDR-1:0] wa,
  output logic [W_DATA-1:0] wd,
  output logic              frame_err,
  output logic              ovf,
  input  logic              clr_ovf
);

  localparam int             FLen  = frameLen(W_ADDR, W_DATA);
  localparam int             CntW  = $clog2(FLen + 1);
  localparam logic [CntW-1:0] FLenC = CntW'(FLen);

  logic sclkSync, csSync, mosiSync;
  logic sclkPrev_q, csPrev_q;
  logic sclkRise, csFall, csRise;

  rxState_e           state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d, cntInc;
  logic [FLen-1:0]    sreg_q, sreg_d;
  logic               extra_q, extra_d;
  logic               frameErr_q, frameErr_d;
  logic               wrReq_q, wrReq_d;
  logic [W_ADDR-1:0]  wa_q, wa_d;
  logic [W_DATA-1:0]  wd_q, wd_d;
  logic               ovf_q, ovf_d;
  logic [W_ADDR-1:0]  commitAddr;
  logic [W_DATA-1:0]  commitData;
  logic               portFree;

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) uSclkSync (
    .clk(clk), .rst_n(rst), .d_i(sclk), .q_o(sclkSync)
  );
  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) uCsSync (
    .clk(clk), .rst_n(rst), .d_i(cs_n), .q_o(csSync)
  );
  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) uMosiSync (
    .clk(clk), .rst_n(rst), .d_i(mosi), .q_o(mosiSync)
  );

  // Previous synced pin levels for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclkPrev_q <= 1'b0;
      csPrev_q   <= 1'b1;
    end else begin
      sclkPrev_q <= sclkSync;
      csPrev_q   <= csSync;
    end
  end

  assign sclkRise   = sclkSync & ~sclkPrev_q;
  assign csFall     = ~csSync & csPrev_q;
  assign csRise     = csSync & ~csPrev_q;
  assign cntInc     = cnt_q + CntW'(1);
  assign commitAddr = sreg_q[FLen-1 -: W_ADDR];
  assign commitData = sreg_q[W_DATA-1:0];
  // A grant in this cycle retires the outstanding write, so a new one may load.
  assign portFree   = ~wrReq_q | wr_gnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RX_IDLE;
      cnt_q      <= '0;
      sreg_q     <= '0;
      extra_q    <= 1'b0;
      frameErr_q <= 1'b0;
      wrReq_q    <= 1'b0;
      wa_q       <= '0;
      wd_q       <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sreg_q     <= sreg_d;
      extra_q    <= extra_d;
      frameErr_q <= frameErr_d;
      wrReq_q    <= wrReq_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
      ovf_q      <= ovf_d;
    end
  end

  // Next-state logic. The handshake retire and the ovf clear are applied
  // before the FSM case so that a commit in the same cycle overrides them.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sreg_d     = sreg_q;
    extra_d    = extra_q;
    frameErr_d = 1'b0;
    wrReq_d    = wrReq_q;
    wa_d       = wa_q;
    wd_d       = wd_q;
    ovf_d      = ovf_q;

    if (wrReq_q && wr_gnt) begin
      wrReq_d = 1'b0;
    end
    if (clr_ovf) begin
      ovf_d = 1'b0;
    end

    case (state_q)
      RX_IDLE: begin
        if (csFall) begin
          state_d = RX_SHIFT;
          cnt_d   = '0;
        end
      end
      RX_SHIFT: begin
        if (csRise) begin
          frameErr_d = 1'b1;
          state_d    = RX_IDLE;
        end else if (sclkRise) begin
          sreg_d = {sreg_q[FLen-2:0], mosiSync};
          cnt_d  = cntInc;
          if (cntInc == FLenC) begin
            state_d = RX_COMMIT;
          end
        end
      end
      RX_COMMIT: begin
        // Register 0 is hardwired to zero, so such frames are silently dropped.
        if (commitAddr != '0) begin
          if (portFree) begin
            wrReq_d = 1'b1;
            wa_d    = commitAddr;
            wd_d    = commitData;
          end else begin
            ovf_d = 1'b1;
          end
        end
        extra_d = 1'b0;
        state_d = csRise ? RX_IDLE : RX_DRAIN;
      end
      RX_DRAIN: begin
        if (csRise) begin
          state_d = RX_IDLE;
        end else if (sclkRise && !extra_q) begin
          frameErr_d = 1'b1;
          extra_d    = 1'b1;
        end
      end
      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

  assign wr_req    = wrReq_q;
  assign wa        = wa_q;
  assign wd        = wd_q;
  assign frame_err = frameErr_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_spi_regfile_rx.sv
// Self-checking bench for spi_regfile_rx: directed frames from the test plan
// followed by randomized frames, all checked against a frame-level model
// (queue of expected writes, expected error count, expected overflow flag).
module tb_spi_regfile_rx;
  import spi_regfile_rx_pkg::*;

  localparam int WA   = 5;
  localparam int WD   = 32;
  localparam int SYNC = 2;
  localparam int F    = F_LEN;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sclk = 1'b0;
  logic          cs_n = 1'b1;
  logic          mosi = 1'b1;
  logic          wr_gnt = 1'b0;
  logic          clr_ovf = 1'b0;
  logic          wr_req;
  logic [WA-1:0] wa;
  logic [WD-1:0] wd;
  logic          frame_err;
  logic          ovf;

  int compared = 0;
  int mismatched = 0;
  int cycCnt = 0;
  int errExp = 0;
  int errSeen = 0;
  logic ovfExp = 1'b0;
  int reqCycles = 0;
  int reqRiseCyc = 0;
  int lastRiseCyc = 0;
  int gntMode = 0;
  logic prevReq = 1'b0;
  logic [F-1:0] expQ[$];

  spi_regfile_rx #(.W_ADDR(WA), .W_DATA(WD), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .wr_req(wr_req), .wr_gnt(wr_gnt), .wa(wa), .wd(wd),
    .frame_err(frame_err), .ovf(ovf), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  // Free-running cycle counter used for latency measurements.
  always @(posedge clk) cycCnt++;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Grant driver: mode 0 holds grant low, 1 holds it high, 2 randomizes it.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (gntMode)
        0: wr_gnt = 1'b0;
        1: wr_gnt = 1'b1;
        default: wr_gnt = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Write-port monitor: while a request is up it must present the oldest
  // expected write; an accepted request retires it. Also counts error pulses.
  always @(negedge clk) begin
    logic [F-1:0] e;
    if (!rst) begin
      prevReq = 1'b0;
    end else begin
      if (wr_req) begin
        reqCycles++;
        if (!prevReq) reqRiseCyc = cycCnt;
        if (expQ.size() == 0) begin
          checkOutput("unexpected_write", 1, 0);
        end else begin
          e = expQ[0];
          checkOutput("wa", wa, e[F-1 -: WA]);
          checkOutput("wd", wd, e[WD-1:0]);
          if (wr_gnt) void'(expQ.pop_front());
        end
      end
      if (frame_err) errSeen++;
      prevReq = wr_req;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic shiftBit(input logic b);
    mosi = b;
    tick(4);
    sclk = 1'b1;
    lastRiseCyc = cycCnt;
    tick(4);
    sclk = 1'b0;
  endtask

  // Send one cs_n window with nbits bits; the model outcome is decided up
  // front so the expected write is queued before the DUT can present it.
  task automatic applyStimulus(input logic [WA-1:0] a, input logic [WD-1:0] d, input int nbits);
    logic [F-1:0] fr;
    fr = {a, d};
    if (nbits < F) begin
      errExp++;
    end else begin
      if (nbits > F) errExp++;
      if (a != '0) begin
        if (expQ.size() != 0) ovfExp = 1'b1;
        else expQ.push_back(fr);
      end
    end
    cs_n = 1'b0;
    tick(4);
    for (int i = 0; i < nbits; i++) begin
      if (i < F) shiftBit(fr[F-1-i]);
      else shiftBit(1'($urandom));
    end
    tick(4);
    cs_n = 1'b1;
    tick(8);
  endtask

  task automatic waitDrain(input string tag);
    int k;
    k = 0;
    while (expQ.size() != 0 && k < 300) begin
      tick(1);
      k++;
    end
    checkOutput(tag, expQ.size(), 0);
  endtask

  task automatic checkFlags(input string tag);
    checkOutput({tag, "_frame_err_count"}, errSeen, errExp);
    checkOutput({tag, "_ovf"}, ovf, ovfExp);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_wr_req"}, wr_req, 0);
    checkOutput({tag, "_wa"}, wa, 0);
    checkOutput({tag, "_wd"}, wd, 0);
    checkOutput({tag, "_frame_err"}, frame_err, 0);
    checkOutput({tag, "_ovf"}, ovf, 0);
  endtask

  initial begin
    int r0;
    logic [WA-1:0] ra;
    logic [WD-1:0] rd;
    int pick, nb;

    #3 rst = 1'b0;
    tick(3);
    checkAllZero("reset");
    rst = 1'b1;
    tick(3);

    // Basic write with grant tied high: one request cycle, fixed latency.
    gntMode = 1;
    tick(2);
    r0 = reqCycles;
    applyStimulus(5'd8, 32'hDEADBEEF, F);
    waitDrain("t1_drain");
    checkOutput("t1_req_cycles", reqCycles - r0, 1);
    checkOutput("t1_latency", reqRiseCyc - lastRiseCyc, SYNC + 2);
    checkFlags("t1");

    // Address 0 is never written.
    r0 = reqCycles;
    applyStimulus(5'd0, 32'h12345678, F);
    checkOutput("t2_req_cycles", reqCycles - r0, 0);
    checkFlags("t2");

    // Short frame aborts, then a valid frame still works.
    r0 = reqCycles;
    applyStimulus(5'd17, 32'h55AA55AA, 20);
    checkOutput("t3_req_cycles", reqCycles - r0, 0);
    checkFlags("t3_short");
    applyStimulus(5'd3, 32'h1, F);
    waitDrain("t3_drain");
    checkFlags("t3_valid");

    // Pending write blocks a second frame, which sets ovf and is dropped.
    gntMode = 0;
    tick(2);
    applyStimulus(5'd4, 32'hA, F);
    applyStimulus(5'd5, 32'hB, F);
    checkOutput("t4_req_held", wr_req, 1);
    checkOutput("t4_wa_held", wa, 4);
    checkOutput("t4_wd_held", wd, 32'hA);
    checkFlags("t4_ovf_set");
    gntMode = 1;
    waitDrain("t4_drain");
    tick(4);
    checkOutput("t4_req_low", wr_req, 0);
    checkFlags("t4_after_grant");
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    ovfExp = 1'b0;
    checkOutput("t4_ovf_cleared", ovf, 0);

    // Over-long frame: write happens, then one error for the extra bits.
    applyStimulus(5'd9, 32'hCAFEF00D, 40);
    waitDrain("t5_drain");
    checkFlags("t5");

    // Reset in the middle of a frame.
    cs_n = 1'b0;
    tick(4);
    for (int i = 0; i < 15; i++) shiftBit(1'($urandom));
    rst = 1'b0;
    #1;
    checkAllZero("t6_mid_frame");
    cs_n = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(3);

    // Reset while a write is pending discards it.
    gntMode = 0;
    tick(2);
    applyStimulus(5'd7, 32'h0BADF00D, F);
    checkOutput("t6_req_pending", wr_req, 1);
    rst = 1'b0;
    #1;
    checkAllZero("t6_mid_handshake");
    expQ.delete();
    ovfExp = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(3);
    gntMode = 1;
    tick(2);
    applyStimulus(5'd21, 32'h600DCAFE, F);
    waitDrain("t6_drain");
    checkFlags("t6");

    // Randomized frames with a random grant.
    gntMode = 2;
    for (int n = 0; n < 14; n++) begin
      ra = WA'($urandom_range(0, 31));
      rd = $urandom;
      pick = $urandom_range(0, 99);
      if (pick < 70) nb = F;
      else if (pick < 85) nb = $urandom_range(10, F - 1);
      else nb = $urandom_range(F + 1, F + 3);
      applyStimulus(ra, rd, nb);
      waitDrain("rand_drain");
      checkFlags("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
